note_arbiter: RTL and testbench

NOTE_ARBITER -- requirements
Module: note_arbiter

---
 rtl/note_arbiter.sv | 139 +++++++++++++
 tb/tb_note_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_arbiter.sv
// note_arbiter: synchronizes and debounces a 15-key keypad, selects the
// highest pressed key, and presents its oscillator period to the tone
// generator with a load/ack handshake before gating the note on.
module note_arbiter #(
  parameter int unsigned DB_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [14:0] keypad_i,
  input  logic        load_ack_i,
  output logic        load_o,
  output logic [15:0] period_o,
  output logic [3:0]  note_idx_o,
  output logic        note_valid_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_PLAY} state_t;

  // Index 15 never names a key, so it encodes "no key pressed".
  localparam logic [3:0]  NOTE_NONE = 4'hF;
  localparam logic [15:0] CNT_SAT   = 16'(DB_CYCLES);
  // Counter value one step before it reaches DB_CYCLES-1.
  localparam logic [15:0] CNT_PRE   = 16'(DB_CYCLES - 2);

  logic [14:0] r_sync1, r_sync2;
  logic [3:0]  w_cand, r_prev_cand, r_accepted, r_idx;
  logic [15:0] r_cnt, w_cnt_next, w_period, r_period;
  logic        w_stable, w_accept, w_latch;
  state_t      r_state, w_state_next;

  // Two-flop synchronizer for the asynchronous key levels; keeps running while en is low.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= keypad_i;
      r_sync2 <= r_sync1;
    end
  end

  // Candidate is the highest-index pressed key; later loop iterations override earlier ones.
  // NOTE: the default is assigned first so no path leaves w_cand unassigned (no latch).
  always_comb begin
    w_cand = NOTE_NONE;
    for (int i = 0; i < 15; i++) begin
      if (r_sync2[i]) w_cand = 4'(i);
    end
  end

  assign w_stable   = (w_cand == r_prev_cand);
  assign w_cnt_next = !w_stable          ? 16'd0 :
                      (r_cnt == CNT_SAT) ? r_cnt : r_cnt + 16'd1;
  // Accept on the edge where the counter steps to DB_CYCLES-1 with a new note.
  assign w_accept   = en && w_stable && (r_cnt == CNT_PRE) && (w_cand != r_accepted);

  // Stability counter; forcing prev to "none" while disabled makes a held key requalify fully.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_cnt       <= '0;
      r_prev_cand <= NOTE_NONE;
    end else begin
      r_cnt       <= w_cnt_next;
      r_prev_cand <= w_cand;
    end
  end

  // Accepted note, the reference against which later candidates are judged "different".
  always_ff @(posedge clk) begin
    if (rst || !en)    r_accepted <= NOTE_NONE;
    else if (w_accept) r_accepted <= w_cand;
  end

  // Period ROM: round(10 MHz / f) for equal-tempered C4..D5 with A4 = 440 Hz.
  always_comb begin
    w_period = '0;
    case (w_cand)
      4'd0:    w_period = 16'd38223;
      4'd1:    w_period = 16'd36077;
      4'd2:    w_period = 16'd34052;
      4'd3:    w_period = 16'd32141;
      4'd4:    w_period = 16'd30337;
      4'd5:    w_period = 16'd28635;
      4'd6:    w_period = 16'd27027;
      4'd7:    w_period = 16'd25511;
      4'd8:    w_period = 16'd24079;
      4'd9:    w_period = 16'd22727;
      4'd10:   w_period = 16'd21452;
      4'd11:   w_period = 16'd20248;
      4'd12:   w_period = 16'd19111;
      4'd13:   w_period = 16'd18039;
      4'd14:   w_period = 16'd17026;
      default: w_period = '0;
    endcase
  end

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Next state: a fresh acceptance always wins over an ack arriving in the same cycle.
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    if (!en) begin
      w_state_next = ST_IDLE;
    end else if (w_accept) begin
      if (w_cand == NOTE_NONE) begin
        w_state_next = ST_IDLE;
      end else begin
        w_state_next = ST_LOAD;
        w_latch      = 1'b1;
      end
    end else if (r_state == ST_LOAD && load_ack_i) begin
      w_state_next = ST_PLAY;
    end
  end

  // Presented note and period; hold steady between acceptances.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      r_idx    <= '0;
      r_period <= '0;
    end else if (w_latch) begin
      r_idx    <= w_cand;
      r_period <= w_period;
    end
  end

  assign load_o       = (r_state == ST_LOAD);
  assign note_valid_o = (r_state == ST_PLAY);
  assign note_idx_o   = r_idx;
  assign period_o     = r_period;

endmodule

// File: tb/tb_note_arbiter.sv
// tb_note_arbiter: directed scenarios followed by random keypad/ack/en/rst
// traffic, every edge compared against a behavioural model of the arbiter.
`timescale 1ns/1ps
module tb_note_arbiter;

  localparam int DB     = 4;
  localparam int NONE   = -1;
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_PLAY = 2;

  logic        clk = 1'b0;
  logic        rst, en, load_ack_i;
  logic [14:0] keypad_i;
  logic        load_o, note_valid_o;
  logic [15:0] period_o;
  logic [3:0]  note_idx_o;

  int checks = 0;
  int errors = 0;
  string step = "init";

  // Model: key history behind the 2-edge synchronizer delay, run length of the
  // current candidate, accepted note and handshake mode.
  logic [14:0] m_s1 = '0, m_s2 = '0;
  int m_last = NONE, m_run = 0, m_acc = NONE, m_mode = M_IDLE;
  int m_idx = 0, m_per = 0;

  note_arbiter #(.DB_CYCLES(DB)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .keypad_i     (keypad_i),
    .load_ack_i   (load_ack_i),
    .load_o       (load_o),
    .period_o     (period_o),
    .note_idx_o   (note_idx_o),
    .note_valid_o (note_valid_o)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0d expected=%0d", step, tag, obs, exp);
    end
  endtask

  // Highest pressed key index, or NONE, by arithmetic on the key mask.
  function automatic int top_key(input logic [14:0] k);
    return $clog2(int'(k) + 1) - 1;
  endfunction

  // Equal-tempered period in 10 MHz cycles, A4 (index 9) = 440 Hz.
  function automatic int ref_period(input int idx);
    real f;
    f = 440.0 * (2.0 ** ((idx - 9) / 12.0));
    return $rtoi($floor(1.0e7 / f + 0.5));
  endfunction

  task automatic model_edge();
    int cand;
    bit accept;
    if (rst) begin
      m_s1 = '0; m_s2 = '0;
      m_last = NONE; m_run = 0; m_acc = NONE;
      m_mode = M_IDLE; m_idx = 0; m_per = 0;
      return;
    end
    cand = top_key(m_s2);
    m_s2 = m_s1;
    m_s1 = keypad_i;
    if (!en) begin
      m_last = NONE; m_run = 0; m_acc = NONE;
      m_mode = M_IDLE; m_idx = 0; m_per = 0;
      return;
    end
    if (m_run > 0 && cand == m_last) begin
      if (m_run <= DB) m_run++;
    end else begin
      m_run = 1;
    end
    m_last = cand;
    accept = (m_run == DB) && (cand != m_acc);
    if (accept) begin
      m_acc = cand;
      if (cand == NONE) begin
        m_mode = M_IDLE;
      end else begin
        m_mode = M_LOAD;
        m_idx  = cand;
        m_per  = ref_period(cand);
      end
    end else if (m_mode == M_LOAD && load_ack_i) begin
      m_mode = M_PLAY;
    end
  endtask

  // One rising edge: advance the model, then compare all outputs 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("load_o",       32'(load_o),       32'(m_mode == M_LOAD));
    check("note_valid_o", 32'(note_valid_o), 32'(m_mode == M_PLAY));
    check("note_idx_o",   32'(note_idx_o),   32'(m_idx));
    check("period_o",     32'(period_o),     32'(m_per));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_load"},  32'(load_o),       32'd0);
    check({tag, "_valid"}, 32'(note_valid_o), 32'd0);
    check({tag, "_idx"},   32'(note_idx_o),   32'd0);
    check({tag, "_per"},   32'(period_o),     32'd0);
  endtask

  initial begin
    int hold;
    rst = 1'b1; en = 1'b1; keypad_i = '0; load_ack_i = 1'b0;

    // Reset, then one cycle after release with no keys.
    step = "reset";
    repeat (2) tick();
    check_all_zero("during_rst");
    rst = 1'b0;
    tick();
    check_all_zero("after_rst");

    // Lowest key held: load_o on edge DB+2 after the first sampling edge.
    step = "key0";
    keypad_i = 15'h0001;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("load_edge", 32'(load_o), 32'(e == 6));
    end
    check("per0", 32'(period_o), 32'd38223);
    check("idx0", 32'(note_idx_o), 32'd0);
    repeat (3) tick();
    check("load_held", 32'(load_o), 32'd1);
    load_ack_i = 1'b1;
    tick();
    load_ack_i = 1'b0;
    check("valid_after_ack", 32'(note_valid_o), 32'd1);
    check("load_after_ack", 32'(load_o), 32'd0);

    // Two keys: highest wins; releasing it reloads the lower one.
    step = "chord";
    keypad_i = 15'h1200;
    repeat (6) tick();
    check("idx12", 32'(note_idx_o), 32'd12);
    check("per12", 32'(period_o), 32'd19111);
    load_ack_i = 1'b1;
    tick();
    load_ack_i = 1'b0;
    check("play12", 32'(note_valid_o), 32'd1);
    keypad_i = 15'h0200;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("valid_drop", 32'(note_valid_o), 32'(e < 6));
    end
    check("idx9", 32'(note_idx_o), 32'd9);
    check("per9", 32'(period_o), 32'd22727);
    check("load9", 32'(load_o), 32'd1);
    load_ack_i = 1'b1;
    tick();
    load_ack_i = 1'b0;

    // Release to idle, then a 2-cycle glitch on key 14 must be ignored.
    step = "glitch";
    keypad_i = '0;
    repeat (6) tick();
    check("idle_valid", 32'(note_valid_o), 32'd0);
    keypad_i = 15'h4000;
    repeat (2) tick();
    keypad_i = '0;
    for (int e = 0; e < 12; e++) begin
      tick();
      check("no_load", 32'(load_o), 32'd0);
    end
    check("idx_kept", 32'(note_idx_o), 32'd9);

    // Acceptance coinciding with ack: stays in LOAD with the new note.
    step = "ack_race";
    keypad_i = 15'h0008;
    repeat (6) tick();
    check("idx3", 32'(note_idx_o), 32'd3);
    check("per3", 32'(period_o), 32'd32141);
    keypad_i = 15'h0080;
    repeat (5) tick();
    load_ack_i = 1'b1;
    tick();
    load_ack_i = 1'b0;
    check("race_load", 32'(load_o), 32'd1);
    check("race_valid", 32'(note_valid_o), 32'd0);
    check("race_idx", 32'(note_idx_o), 32'd7);
    check("race_per", 32'(period_o), 32'd25511);
    tick();
    check("still_load", 32'(load_o), 32'd1);
    load_ack_i = 1'b1;
    tick();
    load_ack_i = 1'b0;
    check("late_ack_play", 32'(note_valid_o), 32'd1);

    // en dropped in PLAY, requalification on re-enable, reset mid-LOAD.
    step = "en_rst";
    en = 1'b0;
    tick();
    check_all_zero("en_off");
    tick();
    en = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check("requal", 32'(load_o), 32'(e == 4));
    end
    check("requal_idx", 32'(note_idx_o), 32'd7);
    rst = 1'b1;
    tick();
    check_all_zero("rst_in_load");
    rst = 1'b0;
    tick();

    // Random traffic against the model.
    step = "random";
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 3))
          0:       keypad_i = '0;
          1, 2:    keypad_i = 15'(1) << $urandom_range(0, 14);
          default: keypad_i = 15'($urandom) & 15'($urandom);
        endcase
        hold = $urandom_range(1, 10);
      end else begin
        hold--;
      end
      load_ack_i = ($urandom_range(0, 3) == 0);
      en         = ($urandom_range(0, 59) != 0);
      rst        = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
